// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op encodings, driver FSM states and the buffered command layout.
package alu_pkg;
    localparam int W = 8;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    typedef struct packed {
        logic         chain;
        logic [1:0]   op;
        logic [W-1:0] b;
        logic [W-1:0] a;
    } cmd_t;
endpackage

// File: rtl/alu_cmd_driver_if.sv
// alu_cmd_driver_if: command and response valid/ready streams of the ALU command driver.
interface alu_cmd_driver_if #(parameter int W = 8);
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_a;
    logic [W-1:0] cmd_b;
    logic [1:0]   cmd_op;
    logic         cmd_chain;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_result;
    logic [1:0]   rsp_op;
    logic         rsp_zero;
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_zero
    );
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_chain, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_op, rsp_zero
    );
endinterface

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: first-word-fall-through synchronous FIFO holding pending ALU commands.
module alu_cmd_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [W-1:0]                 din,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;
    assign full    = count == FULL_COUNT;
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            if (do_push && !do_pop) count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= din;
    end
endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: buffers ALU commands, drives the ALU from registers and returns results in order.
module alu_cmd_driver
    import alu_pkg::*;
#(
    parameter int W     = alu_pkg::W,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    alu_cmd_driver_if.slave     bus,
    output logic [W-1:0]        alu_a,
    output logic [W-1:0]        alu_b,
    output logic [1:0]          alu_op,
    input  logic [W-1:0]        alu_result,
    output logic                busy
);
    state_t                       state;
    state_t                       next;
    cmd_t                         din;
    cmd_t                         head;
    logic                         push;
    logic                         pop;
    logic                         full;
    logic                         empty;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic [W-1:0]                 result;
    logic [1:0]                   result_op;
    assign din            = '{chain: bus.cmd_chain, op: bus.cmd_op, b: bus.cmd_b, a: bus.cmd_a};
    assign push           = bus.cmd_valid && !full;
    assign bus.cmd_ready  = !full;
    assign bus.rsp_valid  = state == RESP;
    assign bus.rsp_result = result;
    assign bus.rsp_op     = result_op;
    assign bus.rsp_zero   = result == '0;
    assign busy           = state != IDLE || count != '0;
    alu_cmd_fifo #(.W($bits(cmd_t)), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= next;
    end
    // A pop is only ever taken when the ALU path is free: from IDLE, or as a response retires.
    always_comb begin
        pop  = !empty && (state == IDLE || (state == RESP && bus.rsp_ready));
        next = state == ISSUE ? RESP :
               pop ? ISSUE :
               (state == RESP && bus.rsp_ready) ? IDLE : state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            result    <= '0;
            result_op <= '0;
        end else begin
            if (pop) begin
                alu_a  <= head.chain ? result : head.a;
                alu_b  <= head.b;
                alu_op <= head.op;
            end
            if (state == ISSUE) begin
                result    <= alu_result;
                result_op <= alu_op;
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// tb_alu_cmd_driver: scoreboard bench for alu_cmd_driver with a behavioural ALU attached.
module tb_alu_cmd_driver;
    import alu_pkg::*;
    typedef struct {
        logic [7:0] res;
        logic [1:0] op;
    } exp_t;
    logic       clk;
    logic       rst;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       busy;
    int         errors;
    int         checks;
    exp_t       sb[$];
    alu_cmd_driver_if #(.W(8)) bus ();
    alu_cmd_driver #(.W(8), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .busy       (busy)
    );
    always_comb
        alu_result = alu_op == OP_ADD ? alu_a + alu_b :
                     alu_op == OP_SUB ? alu_a - alu_b :
                     alu_op == OP_AND ? alu_a & alu_b : alu_a | alu_b;
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic send(input logic chain, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] exp_res, output bit ok);
        bit acc;
        exp_t e;
        ok = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_chain = chain;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        for (int i = 0; i < 50 && !ok; i++) begin
            acc = bus.cmd_ready;
            @(posedge clk);
            #1;
            ok = acc;
        end
        bus.cmd_valid = 1'b0;
        if (ok) begin
            e.res = exp_res;
            e.op  = op;
            sb.push_back(e);
        end
    endtask
    task automatic recv(output logic [7:0] r, output logic [1:0] o, output logic z, output bit ok);
        ok = 0;
        for (int i = 0; i < 50 && !bus.rsp_valid; i++) begin
            @(posedge clk);
            #1;
        end
        r = bus.rsp_result;
        o = bus.rsp_op;
        z = bus.rsp_zero;
        if (bus.rsp_valid) begin
            ok = 1;
            bus.rsp_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.rsp_ready = 1'b0;
        end
    endtask
    task automatic test_reset;
        #12;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
        checks++; if (bus.rsp_zero !== 1'b1) begin errors++; $display("FAIL reset_rsp_zero got=%b want=1", bus.rsp_zero); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b want=1", bus.cmd_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        checks++; if ({alu_a, alu_b, alu_op, bus.rsp_result, bus.rsp_op} !== 28'h0) begin
            errors++; $display("FAIL reset_regs got=%h want=0", {alu_a, alu_b, alu_op, bus.rsp_result, bus.rsp_op}); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got valid=%b busy=%b want 0 0", bus.rsp_valid, busy); end
    endtask
    task automatic test_latency;
        bit ok;
        logic [7:0] r;
        logic [1:0] o;
        logic z;
        exp_t e;
        send(1'b0, OP_ADD, 8'h05, 8'h03, 8'h08, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lat_accept got=timeout want=accepted"); end
        checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL lat_e0 got valid=%b busy=%b want 0 1", bus.rsp_valid, busy); end
        @(posedge clk);
        #1;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL lat_e1 got=%b want=0", bus.rsp_valid); end
        @(posedge clk);
        #1;
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL lat_e2 got=%b want=1", bus.rsp_valid); end
        recv(r, o, z, ok);
        e = sb.pop_front();
        checks++; if (!ok || r !== e.res || o !== e.op || z !== 1'b0) begin
            errors++; $display("FAIL lat_rsp got=%h/%b/%b want=%h/%b/0", r, o, z, e.res, e.op); end
    endtask
    task automatic test_ops;
        bit ok;
        logic [7:0] r;
        logic [1:0] o;
        logic z;
        exp_t e;
        send(1'b0, OP_SUB, 8'h03, 8'h05, 8'hFE, ok);
        send(1'b0, OP_ADD, 8'hFF, 8'h01, 8'h00, ok);
        send(1'b0, OP_AND, 8'hA5, 8'h0F, 8'h05, ok);
        send(1'b0, OP_OR,  8'hA5, 8'h0F, 8'hAF, ok);
        checks++; if (sb.size() != 4) begin errors++; $display("FAIL ops_accept got=%0d want=4", sb.size()); end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            recv(r, o, z, ok);
            checks++; if (!ok || r !== e.res || o !== e.op || z !== (e.res == 8'h00)) begin
                errors++; $display("FAIL ops_rsp got=%h/%b/%b want=%h/%b/%b", r, o, z, e.res, e.op, e.res == 8'h00); end
        end
    endtask
    task automatic test_chain;
        bit ok;
        logic [7:0] r;
        logic [1:0] o;
        logic z;
        exp_t e;
        send(1'b0, OP_ADD, 8'h10, 8'h20, 8'h30, ok);
        send(1'b1, OP_SUB, 8'hEE, 8'h30, 8'h00, ok);
        e = sb.pop_front();
        recv(r, o, z, ok);
        checks++; if (!ok || r !== e.res || o !== e.op) begin
            errors++; $display("FAIL chain_first got=%h/%b want=%h/%b", r, o, e.res, e.op); end
        checks++; if (alu_a !== 8'h30 || alu_b !== 8'h30 || alu_op !== OP_SUB) begin
            errors++; $display("FAIL chain_issue got a=%h b=%h op=%b want 30 30 01", alu_a, alu_b, alu_op); end
        e = sb.pop_front();
        recv(r, o, z, ok);
        checks++; if (!ok || r !== e.res || o !== e.op || z !== 1'b1) begin
            errors++; $display("FAIL chain_second got=%h/%b/%b want=%h/%b/1", r, o, z, e.res, e.op); end
    endtask
    task automatic test_back_to_back;
        bit ok;
        bit acc;
        int n_acc;
        logic [7:0] r;
        logic [1:0] o;
        logic z;
        exp_t e;
        n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_chain = 1'b0;
            bus.cmd_op    = OP_ADD;
            bus.cmd_a     = 8'h10 * 8'(i + 1);
            bus.cmd_b     = 8'h01;
            acc = bus.cmd_ready;
            if (acc) begin
                e.res = 8'h10 * 8'(i + 1) + 8'h01;
                e.op  = OP_ADD;
                sb.push_back(e);
                n_acc++;
            end
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        checks++; if (n_acc != 5) begin errors++; $display("FAIL bp_accepted got=%0d want=5", n_acc); end
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low got=%b want=0", bus.cmd_ready); end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'h11 || bus.rsp_op !== OP_ADD) begin
            errors++; $display("FAIL bp_hold got=%b/%h/%b want=1/11/00", bus.rsp_valid, bus.rsp_result, bus.rsp_op); end
        e = sb.pop_front();
        recv(r, o, z, ok);
        checks++; if (!ok || r !== e.res || o !== e.op) begin
            errors++; $display("FAIL bp_rsp0 got=%h/%b want=%h/%b", r, o, e.res, e.op); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_rise got=%b want=1", bus.cmd_ready); end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            recv(r, o, z, ok);
            checks++; if (!ok || r !== e.res || o !== e.op) begin
                errors++; $display("FAIL bp_rsp got=%h/%b want=%h/%b", r, o, e.res, e.op); end
        end
    endtask
    task automatic test_async_reset;
        bit ok;
        logic [7:0] r;
        logic [1:0] o;
        logic z;
        exp_t e;
        send(1'b0, OP_ADD, 8'h12, 8'h34, 8'h46, ok);
        for (int i = 0; i < 50 && !bus.rsp_valid; i++) begin
            @(posedge clk);
            #1;
        end
        checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 8'h46) begin
            errors++; $display("FAIL ar_pre got=%b/%h want=1/46", bus.rsp_valid, bus.rsp_result); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL ar_flags got valid=%b busy=%b want 0 0", bus.rsp_valid, busy); end
        checks++; if ({alu_a, alu_b, alu_op, bus.rsp_result} !== 26'h0 || bus.rsp_zero !== 1'b1) begin
            errors++; $display("FAIL ar_regs got=%h zero=%b want=0 zero=1", {alu_a, alu_b, alu_op, bus.rsp_result}, bus.rsp_zero); end
        sb.delete();
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL ar_release got ready=%b valid=%b want 1 0", bus.cmd_ready, bus.rsp_valid); end
        send(1'b1, OP_ADD, 8'hCC, 8'h07, 8'h07, ok);
        e = sb.pop_front();
        recv(r, o, z, ok);
        checks++; if (!ok || r !== e.res || o !== e.op || z !== 1'b0) begin
            errors++; $display("FAIL ar_chain got=%h/%b/%b want=%h/%b/0", r, o, z, e.res, e.op); end
    endtask
    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_chain = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_a     = 8'h00;
        bus.cmd_b     = 8'h00;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_latency();
        test_ops();
        test_chain();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
